// File: rtl/hazard_ctrl.sv
// hazard_ctrl: decode->execute issue control with register scoreboard, depth limit and jump flush window.
module hazard_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int MAX_INFLIGHT = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dec_valid_i,
  input  logic [31:0] dec_inst_i,
  input  logic        ex_ready_i,
  input  logic        jumptaken_i,
  input  logic        wb_valid_i,
  input  logic [4:0]  wb_rd_i,
  output logic        dec_stall_o,
  output logic        issue_o,
  output logic        flush_o,
  output logic [31:0] sb_o,
  output logic [3:0]  inflight_o,
  output logic        err_o
);
  localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  typedef enum logic {RUN, FLUSH} state_t;
  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [31:0]     r_sb;
  logic [3:0]      r_inflight;
  logic            r_err;
  logic [6:0]      w_opc;
  logic [4:0]      w_rs1, w_rs2, w_rd;
  logic            w_uses_rs1, w_uses_rs2, w_writes_rd, w_hazard, w_flush, w_issue;
  logic [31:0]     w_set, w_clr;
  assign w_opc = dec_inst_i[6:0];
  assign w_rs1 = dec_inst_i[19:15];
  assign w_rs2 = dec_inst_i[24:20];
  assign w_rd  = dec_inst_i[11:7];
  assign w_uses_rs1  = w_opc inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1100111};
  assign w_uses_rs2  = w_opc inside {7'b0110011, 7'b0100011, 7'b1100011};
  assign w_writes_rd = (w_rd != 5'd0) &&
    (w_opc inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111});
  // Hazards look only at registered state, so a retire frees decode one cycle later.
  assign w_hazard = (w_uses_rs1 && w_rs1 != 5'd0 && r_sb[w_rs1])
                  | (w_uses_rs2 && w_rs2 != 5'd0 && r_sb[w_rs2])
                  | (w_writes_rd && r_sb[w_rd])
                  | (r_inflight == 4'(MAX_INFLIGHT));
  assign w_flush = jumptaken_i | (r_state == FLUSH);
  assign dec_stall_o = dec_valid_i & (w_hazard | w_flush);
  assign w_issue = dec_valid_i & ex_ready_i & ~dec_stall_o;
  assign issue_o = w_issue;
  assign flush_o = w_flush;
  assign sb_o = r_sb;
  assign inflight_o = r_inflight;
  assign err_o = r_err;
  assign w_set = (w_issue && w_writes_rd) ? (32'd1 << w_rd) : 32'd0;
  assign w_clr = (wb_valid_i && wb_rd_i != 5'd0) ? (32'd1 << wb_rd_i) : 32'd0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= RUN;
      r_cnt      <= '0;
      r_sb       <= '0;
      r_inflight <= '0;
      r_err      <= 1'b0;
    end else begin
      r_sb <= ((r_sb & ~w_clr) | w_set) & 32'hFFFF_FFFE;
      if (wb_valid_i && r_inflight == 4'd0) r_err <= 1'b1;
      if (w_issue && !wb_valid_i) r_inflight <= r_inflight + 4'd1;
      else if (!w_issue && wb_valid_i && r_inflight != 4'd0) r_inflight <= r_inflight - 4'd1;
      if (jumptaken_i) begin
        r_state <= FLUSH;
        r_cnt   <= CW'(FLUSH_CYCLES - 1);
      end else if (r_state == FLUSH) begin
        if (r_cnt == '0) r_state <= RUN;
        else r_cnt <= r_cnt - 1'b1;
      end
    end
  end
endmodule
